// File: rtl/vga_sync_gen.sv
// VGA sync generator: clock divider, pixel/line counters, registered syncs and
// per-line / per-frame strobes for the display path and game logic.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS     = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS     = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START  = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START  = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_pix_x;
    logic [9:0]       r_pix_y;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_line_start;
    logic             r_frame_start;

    logic             w_div_last;
    logic             w_tick;
    logic             w_x_last;
    logic             w_y_last;
    logic [9:0]       w_x_next;
    logic [9:0]       w_y_next;

    // Tick is masked by reset so no pixel advance is visible while held in reset.
    assign w_div_last = (r_div_cnt == DIV_LAST);
    assign w_tick     = w_div_last && !reset;
    assign w_x_last   = (r_pix_x == H_LAST);
    assign w_y_last   = (r_pix_y == V_LAST);

    always_comb begin
        w_x_next = r_pix_x;
        w_y_next = r_pix_y;
        if (w_tick) begin
            w_x_next = w_x_last ? 10'd0 : r_pix_x + 10'd1;
            if (w_x_last)
                w_y_next = w_y_last ? 10'd0 : r_pix_y + 10'd1;
        end
    end

    // Syncs are computed from the next counter values so they line up with pix_x/pix_y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_div_last ? '0 : r_div_cnt + 1'b1;
            r_pix_x       <= w_x_next;
            r_pix_y       <= w_y_next;
            r_hsync       <= !((w_x_next >= HS_START) && (w_x_next <= HS_END));
            r_vsync       <= !((w_y_next >= VS_START) && (w_y_next <= VS_END));
            r_line_start  <= w_tick && w_x_last;
            r_frame_start <= w_tick && w_x_last && w_y_last;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign p_tick      = w_tick;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign video_on    = (r_pix_x < H_VIS) && (r_pix_y < V_VIS);
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two instances (full-width lines with a short frame,
// and a tiny CLK_DIV=1 raster), checked against closed-form timing every cycle.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Instance A: default horizontal timing, CLK_DIV=2, short frame (V_TOTAL=12).
    logic       reset_a;
    logic       hs_a, vs_a, von_a, pt_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut_a (
        .clk(clk), .reset(reset_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
        .p_tick(pt_a), .pix_x(x_a), .pix_y(y_a), .line_start(ls_a), .frame_start(fs_a)
    );

    // Instance B: tiny raster, 14 x 7, one clock per pixel.
    logic       reset_b;
    logic       hs_b, vs_b, von_b, pt_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;
    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_b (
        .clk(clk), .reset(reset_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
        .p_tick(pt_b), .pix_x(x_b), .pix_y(y_b), .line_start(ls_b), .frame_start(fs_b)
    );

    // Clock edges seen since the last reset release.
    int e_a = 0;
    int e_b = 0;
    always @(posedge clk or posedge reset_a) if (reset_a) e_a <= 0; else e_a <= e_a + 1;
    always @(posedge clk or posedge reset_b) if (reset_b) e_b <= 0; else e_b <= e_b + 1;

    // Expected outputs after e edges, from pixel count arithmetic alone.
    // Packing: {hsync, vsync, video_on, p_tick, line_start, frame_start, pix_x, pix_y}
    function automatic logic [25:0] model(int e, bit rst, int d, int hd, int hf, int hs,
                                          int hb, int vd, int vf, int vs, int vb);
        int ht, vt, p, x, y;
        bit tick, adv, ls, fs, hsn, vsn, von;
        if (rst) return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
        ht   = hd + hf + hs + hb;
        vt   = vd + vf + vs + vb;
        p    = e / d;
        x    = p % ht;
        y    = (p / ht) % vt;
        tick = (e % d) == d - 1;
        adv  = (e > 0) && (e % d == 0);
        ls   = adv && (x == 0);
        fs   = ls && (y == 0);
        hsn  = !((x >= hd + hf) && (x < hd + hf + hs));
        vsn  = !((y >= vd + vf) && (y < vd + vf + vs));
        von  = (x < hd) && (y < vd);
        return {hsn, vsn, von, tick, ls, fs, 10'(x), 10'(y)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [25:0] act_v, exp_v;
            act_v = {hs_a, vs_a, von_a, pt_a, ls_a, fs_a, x_a, y_a};
            exp_v = model(e_a, reset_a, 2, 640, 16, 96, 48, 6, 2, 2, 2);
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_a e=%0d: got %h expected %h", e_a, act_v, exp_v);
            end
            act_v = {hs_b, vs_b, von_b, pt_b, ls_b, fs_b, x_b, y_b};
            exp_v = model(e_b, reset_b, 1, 8, 2, 2, 2, 4, 1, 1, 1);
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_b e=%0d: got %h expected %h", e_b, act_v, exp_v);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic run_a();
        int ls_e, fs_e, fs_cnt, hs_low, von_hi, vs_low, von_bad;
        bit found;
        ls_e = -1; fs_e = -1; fs_cnt = 0; hs_low = 0; von_hi = 0; vs_low = 0; von_bad = 0;
        // One frame plus a few clocks.
        for (int i = 0; i < 19210; i++) begin
            @(negedge clk);
            if (ls_a && ls_e < 0) ls_e = e_a;
            if (fs_a) begin
                fs_cnt++;
                if (fs_e < 0) fs_e = e_a;
            end
            if (pt_a && e_a < 19200) begin
                if (y_a == 10'd1 && !hs_a) hs_low++;
                if (y_a == 10'd1 && von_a) von_hi++;
                if (!vs_a) vs_low++;
                if (von_a && y_a >= 10'd6) von_bad++;
            end
        end
        check("a_first_line_start_clk", ls_e, 1600);
        check("a_first_frame_start_clk", fs_e, 19200);
        check("a_frame_start_count", fs_cnt, 1);
        check("a_hsync_low_ticks", hs_low, 96);
        check("a_video_on_ticks_line", von_hi, 640);
        check("a_vsync_low_ticks", vs_low, 1600);
        check("a_video_on_below_display", von_bad, 0);

        // Corner (799, 11): next tick wraps both counters.
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge clk);
            if (pt_a && x_a == 10'd799 && y_a == 10'd11) found = 1'b1;
        end
        check("a_corner_reached", int'(found), 1);
        @(negedge clk);
        check("a_corner_x", int'(x_a), 0);
        check("a_corner_y", int'(y_a), 0);
        check("a_corner_line_start", int'(ls_a), 1);
        check("a_corner_frame_start", int'(fs_a), 1);
        @(negedge clk);
        check("a_corner_line_start_off", int'(ls_a), 0);
        check("a_corner_frame_start_off", int'(fs_a), 0);

        // Mid-frame reset during hsync.
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge clk);
            if (x_a == 10'd700 && y_a == 10'd3) found = 1'b1;
        end
        check("a_mid_point_reached", int'(found), 1);
        check("a_mid_hsync_before", int'(hs_a), 0);
        #1 reset_a = 1'b1;
        #1;
        check("a_mid_hsync", int'(hs_a), 1);
        check("a_mid_x", int'(x_a), 0);
        check("a_mid_y", int'(y_a), 0);
        check("a_mid_strobes", int'({pt_a, ls_a, fs_a}), 0);
        check("a_mid_video_on", int'(von_a), 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset_a = 1'b0;
        ls_e = -1;
        for (int i = 0; i < 2000 && ls_e < 0; i++) begin
            @(negedge clk);
            if (ls_a) ls_e = e_a;
        end
        check("a_restart_line_start_clk", ls_e, 1600);
        check("a_restart_line_y", int'(y_a), 1);
        $display("A sequence done at e=%0d", e_a);
    endtask

    task automatic run_b();
        int fs_e[4];
        int n, hs_low, vs_low, von_hi;
        n = 0; hs_low = 0; vs_low = 0; von_hi = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            @(negedge clk);
            if (fs_b) begin
                fs_e[n] = e_b;
                n++;
            end
            if (pt_b && n == 1) begin
                if (!hs_b) hs_low++;
                if (!vs_b) vs_low++;
                if (von_b) von_hi++;
            end
        end
        check("b_frame_start_count", n, 4);
        check("b_first_frame_start_clk", fs_e[0], 98);
        for (int k = 1; k < 4; k++) check("b_frame_interval", fs_e[k] - fs_e[k-1], 98);
        check("b_hsync_low_ticks", hs_low, 14);
        check("b_vsync_low_ticks", vs_low, 14);
        check("b_video_on_ticks", von_hi, 32);
        $display("B sequence done, frame_start at %0d %0d %0d %0d",
                 fs_e[0], fs_e[1], fs_e[2], fs_e[3]);
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_a_x", int'(x_a), 0);
        check("rst_a_y", int'(y_a), 0);
        check("rst_a_syncs", int'({hs_a, vs_a}), 3);
        check("rst_a_video_on", int'(von_a), 1);
        check("rst_a_strobes", int'({pt_a, ls_a, fs_a}), 0);
        check("rst_b_p_tick", int'(pt_b), 0);
        @(posedge clk);
        #2;
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);
        check("rel_a_p_tick_first", int'(pt_a), 0);
        check("rel_b_p_tick_first", int'(pt_b), 1);
        @(negedge clk);
        check("rel_a_p_tick_second", int'(pt_a), 1);
        fork
            run_a();
            run_b();
        join
        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA 640x480@60 timing for the snake game display path.
- Divides the 50 MHz system clock into a 25 MHz pixel tick.
- Produces pix_x, pix_y and video_on, which the graphics generator consumes, plus registered hsync/vsync for the connector.
- Also emits frame and line strobes so game logic can step once per frame instead of using free-running delay counters.

Parameters:
- CLK_DIV, 2, system clocks per pixel; must be ≥1.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- hsync  out  1  horizontal sync, active-low, registered.
- vsync  out  1  vertical sync, active-low, registered.
- video_on  out  1  high when the current pixel is inside the visible area.
- p_tick  out  1  one-clk pulse marking each pixel advance.
- pix_x  out  10  current horizontal counter, 0..H_TOTAL-1.
- pix_y  out  10  current vertical counter, 0..V_TOTAL-1.
- line_start  out  1  one-clk pulse when pix_x wraps to 0.
- frame_start  out  1  one-clk pulse when pix_x and pix_y both wrap to 0.

Behaviour:
- Derived values: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Reset (asynchronous assert; release on the next clk edge). All of the following hold while reset is high:
  - div_cnt=0, pix_x=0, pix_y=0.
  - hsync=1, vsync=1.
  - p_tick, line_start, frame_start all 0.
  - video_on=1, since (0,0) is visible.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick is high in the clk where div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, p_tick is high every clk after reset release.
- Counters advance only on clk edges where p_tick is high:
  - pix_x increments; at H_TOTAL-1 it wraps to 0.
  - pix_y increments only in the same edge where pix_x wraps; at V_TOTAL-1 it wraps to 0.
  - Both wrap in the same edge at the (H_TOTAL-1, V_TOTAL-1) corner.
- Strobes:
  - line_start is high for exactly one clk, in the clk immediately after a pix_x wrap.
  - frame_start is the same, but only for the joint wrap; line_start is also high in that clk.
- Sync outputs are registered from the next counter values, so they align with pix_x/pix_y with zero cycle skew:
  - hsync=0 iff pix_x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751].
  - vsync=0 iff pix_y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490, 491].
- video_on = (pix_x < H_DISPLAY) && (pix_y < V_DISPLAY). It is combinational from the registered counters and glitch-free in practice.
- Counters never exceed TOTAL-1; no invalid states exist.
- Reset mid-frame returns everything to the reset state immediately. The first line after release is complete, with no runt strobes.
- The block has no state machine beyond the three counters; all outputs are functions of the counter registers.

Test Plan:
- Reset, then 1 frame, CLK_DIV=2 → p_tick every 2nd clk. First line_start after 1600 clks. frame_start after 800×525×2 = 840000 clks. No other frame_start pulses.
- Sample on p_tick across one line → hsync low at pix_x=656..751 (96 ticks), high elsewhere. video_on high for pix_x 0..639, low 640..799.
- Run one frame → vsync low only while pix_y=490..491, i.e. 1600 pixel ticks. video_on never high for pix_y ≥ 480.
- Check the corner pix_x=799, pix_y=524 → the next p_tick gives (0,0), with line_start and frame_start both 1 for exactly one clk.
- Assert reset at pix_x=700 (hsync low), pix_y=300 → same cycle gives hsync=1, pix_x=0, pix_y=0, no strobes. After release the line timing restarts from 0.
- Reconfigure CLK_DIV=1, H_DISPLAY=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_DISPLAY=4, V_FRONT=1, V_SYNC=1, V_BACK=1 → H_TOTAL=14, V_TOTAL=7. frame_start every 98 clks. hsync low at pix_x 10..11, vsync low at pix_y 5.
